// File: rtl/fifo_level_trigger_v2.sv
// fifo_level_trigger_v2
//
// Purpose:
//   Watches frame-FIFO occupancy plus the write/read strobes and raises
//   hysteretic "near full" and "near empty" triggers. Thresholds are given
//   in whole frames, can be reloaded at runtime, and are compared against
//   the projected next level. Because the comparisons are inequalities, a
//   simultaneous read/write or a multi-word jump cannot skip a threshold.
//
// Ports:
//   clk                   in   rising-edge clock for all logic
//   reset                 in   synchronous, active-low reset
//   fifo_wr_en_i          in   a word is written this cycle
//   fifo_rd_en_i          in   a word is read this cycle
//   fifo_level_i          in   [CNT_W] words in the FIFO before this update
//   cfg_load_i            in   one-cycle strobe that captures the cfg fields
//   cfg_hi_frames_i       in   [CFG_W] new upper bound, in frames
//   cfg_lo_frames_i       in   [CFG_W] new lower bound, in frames
//   trigger_FIFO_full_o   out  high while the FSM is in HIGH
//   trigger_FIFO_empty_o  out  high while the FSM is in LOW
//   evt_full_o            out  one-cycle pulse on entry to HIGH
//   evt_empty_o           out  one-cycle pulse on entry to LOW
//   cfg_err_o             out  sticky: the most recent cfg load was rejected
//
// Optional feature (compile-time macro TRIG_HOLDOFF_EN):
//   When defined, every state change loads a down-counter with
//   HOLDOFF_CYCLES and further transitions are blocked until it reaches 0.
//   When undefined, transitions are evaluated every cycle.
//
// Parameter constraints: PRE_TRIG < FRAME_SIZE/2, HOLDOFF_CYCLES >= 1.

module fifo_level_trigger_v2 #(
  parameter int CNT_W          = 21,
  parameter int FRAME_SIZE     = 1280,
  parameter int PRE_TRIG       = 1,
  parameter int CFG_W          = 8,
  parameter int DEF_HI_FRAMES  = 10,
  parameter int DEF_LO_FRAMES  = 2,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_wr_en_i,
  input  logic             fifo_rd_en_i,
  input  logic [CNT_W-1:0] fifo_level_i,
  input  logic             cfg_load_i,
  input  logic [CFG_W-1:0] cfg_hi_frames_i,
  input  logic [CFG_W-1:0] cfg_lo_frames_i,
  output logic             trigger_FIFO_full_o,
  output logic             trigger_FIFO_empty_o,
  output logic             evt_full_o,
  output logic             evt_empty_o,
  output logic             cfg_err_o
);

  // Threshold width: wide enough for FRAME_SIZE * (2^CFG_W - 1) without
  // truncation for any sensible FRAME_SIZE.
  localparam int TW = CNT_W + CFG_W;

  localparam logic [TW-1:0]    FRAME_W  = TW'(FRAME_SIZE);
  localparam logic [TW-1:0]    PRE_W    = TW'(PRE_TRIG);
  localparam logic [CFG_W-1:0] DEF_HI_W = CFG_W'(DEF_HI_FRAMES);
  localparam logic [CFG_W-1:0] DEF_LO_W = CFG_W'(DEF_LO_FRAMES);

  // Elaboration-time guard against parameter sets that break hysteresis.
  if ((2 * PRE_TRIG >= FRAME_SIZE) || (HOLDOFF_CYCLES < 1)) begin : g_bad_params
    $error("fifo_level_trigger_v2: PRE_TRIG must be < FRAME_SIZE/2 and HOLDOFF_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2
  } state_t;

  function automatic logic [TW-1:0] calc_set_hi(input logic [CFG_W-1:0] f);
    return FRAME_W * TW'(f) - PRE_W;
  endfunction

  // Only called with f >= 1 (guaranteed by load validation and defaults).
  function automatic logic [TW-1:0] calc_clr_hi(input logic [CFG_W-1:0] f);
    return FRAME_W * (TW'(f) - TW'(1)) + PRE_W;
  endfunction

  function automatic logic [TW-1:0] calc_set_lo(input logic [CFG_W-1:0] f);
    return FRAME_W * TW'(f) + PRE_W;
  endfunction

  function automatic logic [TW-1:0] calc_clr_lo(input logic [CFG_W-1:0] f);
    return FRAME_W * (TW'(f) + TW'(1)) - PRE_W;
  endfunction

  state_t        state_q, state_cand, next_state;
  logic [TW-1:0] set_hi_q, clr_hi_q, set_lo_q, clr_lo_q;
  logic          evt_full_q, evt_empty_q, cfg_err_q;
  logic [CNT_W:0] proj_level;
  logic [TW-1:0]  proj_w;
  logic [CFG_W:0] lo_plus2;
  logic           cfg_valid;
  logic           trans_ok;

  // Projected next level. A read against an empty FIFO clamps at zero
  // rather than wrapping to a huge value that would look like "full".
  always_comb begin
    proj_level = {1'b0, fifo_level_i};
    if (fifo_wr_en_i && !fifo_rd_en_i) begin
      proj_level = proj_level + (CNT_W+1)'(1);
    end else if (!fifo_wr_en_i && fifo_rd_en_i && (fifo_level_i != '0)) begin
      proj_level = proj_level - (CNT_W+1)'(1);
    end
  end

  assign proj_w = TW'(proj_level);

  // lo+2 is formed one bit wider so a lo near 2^CFG_W cannot wrap and
  // make an invalid pair look valid.
  assign lo_plus2  = {1'b0, cfg_lo_frames_i} + (CFG_W+1)'(2);
  assign cfg_valid = ({1'b0, cfg_hi_frames_i} >= lo_plus2) && (cfg_hi_frames_i != '0);

`ifdef TRIG_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYCLES);

  logic [HW-1:0] hold_cnt_q;

  // Reloaded on every state change; a cfg load deliberately does not
  // restart it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_cnt_q <= '0;
    end else if (next_state != state_q) begin
      hold_cnt_q <= HOLD_INIT;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_q <= hold_cnt_q - HW'(1);
    end
  end

  assign trans_ok = (hold_cnt_q == '0);
`else
  assign trans_ok = 1'b1;
`endif

  // Next-state logic. HIGH and LOW are only left towards NORMAL, so a
  // HIGH-to-LOW swing always spends at least one cycle in NORMAL.
  always_comb begin
    state_cand = state_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (proj_w > set_hi_q) begin
          state_cand = ST_HIGH;
        end else if (proj_w < set_lo_q) begin
          state_cand = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (proj_w < clr_hi_q) begin
          state_cand = ST_NORMAL;
        end
      end
      ST_LOW: begin
        if (proj_w > clr_lo_q) begin
          state_cand = ST_NORMAL;
        end
      end
      default: state_cand = ST_NORMAL;
    endcase
    next_state = trans_ok ? state_cand : state_q;
  end

  // State, event pulses, thresholds and config error. The FSM compares
  // against the registered thresholds, so a load coinciding with a
  // transition takes effect only from the following cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_NORMAL;
      evt_full_q  <= 1'b0;
      evt_empty_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      set_hi_q    <= calc_set_hi(DEF_HI_W);
      clr_hi_q    <= calc_clr_hi(DEF_HI_W);
      set_lo_q    <= calc_set_lo(DEF_LO_W);
      clr_lo_q    <= calc_clr_lo(DEF_LO_W);
    end else begin
      state_q     <= next_state;
      evt_full_q  <= (next_state == ST_HIGH) && (state_q != ST_HIGH);
      evt_empty_q <= (next_state == ST_LOW) && (state_q != ST_LOW);
      if (cfg_load_i) begin
        if (cfg_valid) begin
          cfg_err_q <= 1'b0;
          set_hi_q  <= calc_set_hi(cfg_hi_frames_i);
          clr_hi_q  <= calc_clr_hi(cfg_hi_frames_i);
          set_lo_q  <= calc_set_lo(cfg_lo_frames_i);
          clr_lo_q  <= calc_clr_lo(cfg_lo_frames_i);
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
    end
  end

  assign trigger_FIFO_full_o  = (state_q == ST_HIGH);
  assign trigger_FIFO_empty_o = (state_q == ST_LOW);
  assign evt_full_o           = evt_full_q;
  assign evt_empty_o          = evt_empty_q;
  assign cfg_err_o            = cfg_err_q;

endmodule

// File: tb/tb_fifo_level_trigger_v2.sv
// Self-checking bench for fifo_level_trigger_v2 (default build, default
// parameters: FRAME_SIZE=1280, PRE_TRIG=1, hi=10, lo=2, giving
// SET_HI=12799, CLR_HI=11521, SET_LO=2561, CLR_LO=3839).

module tb_fifo_level_trigger_v2;

   logic        clk;
   logic        reset;
   logic        fifo_wr_en_i;
   logic        fifo_rd_en_i;
   logic [20:0] fifo_level_i;
   logic        cfg_load_i;
   logic [7:0]  cfg_hi_frames_i;
   logic [7:0]  cfg_lo_frames_i;
   logic        trigger_FIFO_full_o;
   logic        trigger_FIFO_empty_o;
   logic        evt_full_o;
   logic        evt_empty_o;
   logic        cfg_err_o;

   int checkCount;
   int failCount;

   fifo_level_trigger_v2 dut (
      .clk                  (clk),
      .reset                (reset),
      .fifo_wr_en_i         (fifo_wr_en_i),
      .fifo_rd_en_i         (fifo_rd_en_i),
      .fifo_level_i         (fifo_level_i),
      .cfg_load_i           (cfg_load_i),
      .cfg_hi_frames_i      (cfg_hi_frames_i),
      .cfg_lo_frames_i      (cfg_lo_frames_i),
      .trigger_FIFO_full_o  (trigger_FIFO_full_o),
      .trigger_FIFO_empty_o (trigger_FIFO_empty_o),
      .evt_full_o           (evt_full_o),
      .evt_empty_o          (evt_empty_o),
      .cfg_err_o            (cfg_err_o)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drives one cycle of inputs, lets one rising edge sample them, then
   // returns 1 ns after the edge so outputs can be checked.
   task automatic applyStimulus(input int level, input bit wr, input bit rd);
      fifo_level_i = 21'(level);
      fifo_wr_en_i = wr;
      fifo_rd_en_i = rd;
      @(posedge clk);
      #1;
      cfg_load_i = 1'b0;
   endtask

   // Same as applyStimulus but with a config load strobe in the same cycle.
   task automatic applyConfig(input int level, input bit wr, input bit rd,
                              input int hi, input int lo);
      cfg_load_i      = 1'b1;
      cfg_hi_frames_i = 8'(hi);
      cfg_lo_frames_i = 8'(lo);
      applyStimulus(level, wr, rd);
   endtask

   initial begin
      checkCount      = 0;
      failCount       = 0;
      reset           = 1'b0;
      fifo_wr_en_i    = 1'b0;
      fifo_rd_en_i    = 1'b0;
      fifo_level_i    = 21'd6000;
      cfg_load_i      = 1'b0;
      cfg_hi_frames_i = 8'd0;
      cfg_lo_frames_i = 8'd0;

      // Reset state
      applyStimulus(6000, 0, 0);
      applyStimulus(6000, 0, 0);
      checkOutput("rst_full",  trigger_FIFO_full_o,  0);
      checkOutput("rst_empty", trigger_FIFO_empty_o, 0);
      checkOutput("rst_evtf",  evt_full_o,           0);
      checkOutput("rst_evte",  evt_empty_o,          0);
      checkOutput("rst_cfge",  cfg_err_o,            0);
      reset = 1'b1;
      applyStimulus(6000, 0, 0);
      checkOutput("mid_full",  trigger_FIFO_full_o,  0);
      checkOutput("mid_empty", trigger_FIFO_empty_o, 0);

      // Exactly at SET_HI with no write: no trigger
      applyStimulus(12799, 0, 0);
      checkOutput("sethi_eq", trigger_FIFO_full_o, 0);

      // Item 1: 12799 + wr -> 12800 > SET_HI
      applyStimulus(12799, 1, 0);
      checkOutput("t1_full", trigger_FIFO_full_o, 1);
      checkOutput("t1_evtf", evt_full_o,          1);
      applyStimulus(12800, 0, 0);
      checkOutput("t1_full_hold", trigger_FIFO_full_o, 1);
      checkOutput("t1_evtf_clr",  evt_full_o,          0);

      // Item 3: leave HIGH only below CLR_HI
      applyStimulus(11522, 0, 1);
      checkOutput("t3_stay", trigger_FIFO_full_o, 1);
      applyStimulus(11521, 0, 1);
      checkOutput("t3_exit", trigger_FIFO_full_o, 0);

      // Item 2: wr and rd together cancel; then a jump crosses
      applyStimulus(12799, 1, 1);
      checkOutput("t2_wrrd", trigger_FIFO_full_o, 0);
      applyStimulus(12800, 0, 0);
      checkOutput("t2_jump", trigger_FIFO_full_o, 1);
      checkOutput("t2_evtf", evt_full_o,          1);
      applyStimulus(6000, 0, 0);
      checkOutput("t2_back", trigger_FIFO_full_o, 0);

      // Item 4: LOW entry/exit boundaries
      applyStimulus(2562, 0, 1);
      checkOutput("t4_nolow", trigger_FIFO_empty_o, 0);
      applyStimulus(2561, 0, 1);
      checkOutput("t4_empty", trigger_FIFO_empty_o, 1);
      checkOutput("t4_evte",  evt_empty_o,          1);
      applyStimulus(2560, 0, 0);
      checkOutput("t4_evte_clr", evt_empty_o,          0);
      applyStimulus(3839, 0, 0);
      checkOutput("t4_clr_eq",   trigger_FIFO_empty_o, 1);
      applyStimulus(3839, 1, 0);
      checkOutput("t4_exit",     trigger_FIFO_empty_o, 0);

      // Read against an empty FIFO clamps to 0 (LOW, not HIGH)
      applyStimulus(0, 0, 1);
      checkOutput("clamp_empty", trigger_FIFO_empty_o, 1);
      checkOutput("clamp_full",  trigger_FIFO_full_o,  0);
      applyStimulus(6000, 0, 0);
      checkOutput("clamp_back",  trigger_FIFO_empty_o, 0);

      // HIGH to LOW jump passes through NORMAL
      applyStimulus(13000, 0, 0);
      checkOutput("jmp_high",  trigger_FIFO_full_o,  1);
      applyStimulus(0, 0, 0);
      checkOutput("jmp_nfull", trigger_FIFO_full_o,  0);
      checkOutput("jmp_nempt", trigger_FIFO_empty_o, 0);
      applyStimulus(0, 0, 0);
      checkOutput("jmp_low",   trigger_FIFO_empty_o, 1);
      applyStimulus(6000, 0, 0);

      // Item 5: invalid load keeps old thresholds
      applyConfig(6000, 0, 0, 3, 2);
      checkOutput("t5_err", cfg_err_o, 1);
      applyStimulus(12799, 1, 0);
      checkOutput("t5_oldthr", trigger_FIFO_full_o, 1);
      checkOutput("t5_err_st", cfg_err_o,           1);
      applyStimulus(6000, 0, 0);
      checkOutput("t5_back",   trigger_FIFO_full_o, 0);

      // Valid load hi=4, lo=1: SET_HI=5119, CLR_HI=3841
      applyConfig(4000, 0, 0, 4, 1);
      checkOutput("t5_err_clr", cfg_err_o,           0);
      checkOutput("t5_ld_full", trigger_FIFO_full_o, 0);
      applyStimulus(5119, 0, 0);
      checkOutput("t5_eq",      trigger_FIFO_full_o, 0);
      applyStimulus(5119, 1, 0);
      checkOutput("t5_newthr",  trigger_FIFO_full_o, 1);
      applyStimulus(3841, 0, 1);
      checkOutput("t5_newclr",  trigger_FIFO_full_o, 0);

      // Load during a transition: the transition uses the old SET_HI=5119
      applyConfig(5119, 1, 0, 10, 2);
      checkOutput("ld_trans_full", trigger_FIFO_full_o, 1);
      checkOutput("ld_trans_err",  cfg_err_o,           0);
      applyStimulus(6000, 0, 0);
      checkOutput("ld_trans_new",  trigger_FIFO_full_o, 0);

      // Item 6: reset while HIGH clears everything
      applyStimulus(13000, 0, 0);
      checkOutput("t6_high", trigger_FIFO_full_o, 1);
      reset = 1'b0;
      applyStimulus(13000, 1, 0);
      checkOutput("t6_full",  trigger_FIFO_full_o,  0);
      checkOutput("t6_evtf",  evt_full_o,           0);
      checkOutput("t6_empty", trigger_FIFO_empty_o, 0);
      reset = 1'b1;
      applyStimulus(6000, 0, 0);
      checkOutput("t6_after", trigger_FIFO_full_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/fifo_level_trigger_v2.md
Name: fifo_level_trigger_v2

Overview:
Parametrised successor to the single-threshold FIFO frame trigger. It watches FIFO occupancy plus the write and read strobes, and raises hysteretic "near full" and "near empty" triggers. Thresholds are in whole frames and can be changed at runtime. Comparisons use inequalities on the projected next level, so simultaneous reads and writes, and multi-word jumps, cannot skip a threshold. It sits beside the frame FIFO and feeds upstream throttling and downstream frame-drop logic.

Parameters:
CNT_W, 21, width of fifo_level_i
FRAME_SIZE, 1280, words per frame
PRE_TRIG, 1, guard words before/after a frame boundary; must be < FRAME_SIZE/2
CFG_W, 8, width of frame-count config fields
DEF_HI_FRAMES, 10, upper bound loaded at reset
DEF_LO_FRAMES, 2, lower bound loaded at reset
HOLDOFF_CYCLES, 16, dwell time used only with TRIG_HOLDOFF_EN

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
fifo_wr_en_i  in  1  word written this cycle
fifo_rd_en_i  in  1  word read this cycle
fifo_level_i  in  CNT_W  words currently in FIFO (pre-update)
cfg_load_i  in  1  one-cycle strobe: capture cfg fields
cfg_hi_frames_i  in  CFG_W  new upper bound (frames)
cfg_lo_frames_i  in  CFG_W  new lower bound (frames)
trigger_FIFO_full_o  out  1  level-high trigger (state HIGH)
trigger_FIFO_empty_o  out  1  level-low trigger (state LOW)
evt_full_o  out  1  one-cycle pulse on entry to HIGH
evt_empty_o  out  1  one-cycle pulse on entry to LOW
cfg_err_o  out  1  sticky: last cfg_load was rejected

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=NORMAL; all outputs 0.
  - Thresholds recomputed from DEF_HI/DEF_LO.
  - Reset overrides any in-flight event or cfg_load.
- Projected level: L' = fifo_level_i + wr - rd, computed CNT_W+1 wide.
  - rd with level 0 clamps L' to 0.
  - Overflow is not checked.
- Registered thresholds, CNT_W+CFG_W bits wide, so no truncation:
  - SET_HI = FRAME_SIZE*hi - PRE_TRIG
  - CLR_HI = FRAME_SIZE*(hi-1) + PRE_TRIG
  - SET_LO = FRAME_SIZE*lo + PRE_TRIG
  - CLR_LO = FRAME_SIZE*(lo+1) - PRE_TRIG
- FSM, evaluated every cycle; at most one transition per cycle:
  - NORMAL -> HIGH if L' > SET_HI. This has priority.
  - NORMAL -> LOW if L' < SET_LO.
  - HIGH -> NORMAL if L' < CLR_HI.
  - LOW -> NORMAL if L' > CLR_LO.
  - A jump from HIGH to LOW passes through NORMAL for at least one cycle.
- Latency: outputs are registered and change on the same edge that samples the causing wr/rd, i.e. zero added cycles.
  - trigger_FIFO_full_o = (state==HIGH); trigger_FIFO_empty_o = (state==LOW).
  - evt_* pulse for exactly the first cycle of the new state.
- Config:
  - cfg_load_i is valid when hi >= lo+2 and hi >= 1.
  - Valid load: thresholds update at the next edge and are used from the following cycle. cfg_err_o clears. The state is not forced; it moves by the normal rules against the new thresholds.
  - Invalid load: thresholds are unchanged and cfg_err_o=1 until the next valid load.
  - cfg_load during a transition cycle: that transition uses the old thresholds.

Optional Feature:
TRIG_HOLDOFF_EN:
- Defined: after any state change, a down-counter is loaded with HOLDOFF_CYCLES. Further transitions are suppressed until it reaches 0, which suppresses chatter.
  - Reset clears the counter.
  - cfg_load does not restart the counter.
- Undefined: there is no counter, and transitions are evaluated every cycle as described above.

Test Plan (FRAME_SIZE=1280, PRE_TRIG=1, hi=10, lo=2 → SET_HI=12799, CLR_HI=11521, SET_LO=2561, CLR_LO=3839):
1. level=12799, wr=1, rd=0 -> full=1 and evt_full=1 at that edge; evt_full=0 on the next cycle.
2. level=12799, wr=1, rd=1 -> L'=12799, no trigger. Then level=12800 jumped in with wr=0 -> full=1.
3. In HIGH: level=11521 with rd -> full=0. Level 11522 with rd -> full stays 1.
4. level=2561 with rd -> empty=1, evt_empty pulse. Then level=3839 with wr -> empty=0.
5. cfg_load hi=3, lo=2 -> cfg_err=1, thresholds unchanged (item 1 still fires at 12799). Then cfg_load hi=4, lo=1 -> cfg_err=0; level=5119 with wr -> full=1.
6. In HIGH, reset=0 for one edge -> all outputs 0. With TRIG_HOLDOFF_EN: a re-cross inside 16 cycles is ignored and takes effect on the first cycle after the holdoff expires.
